// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared constants and FSM state type for the pipeline hazard
//               and sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Core-wide widths (register file address and datapath width).
  localparam int REG_ADDR_WIDTH = 5;
  localparam int XLEN           = 32;

  // Controller sequencing states.
  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hazard_cmp
// Description : Combinational source/destination register match. Flags a hit
//               when a writing (or loading) producer's rd equals either used
//               source operand; x0 never produces a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic              rs1_used_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs2_used_i,
  output logic              hit_o
);

  // x0 is hardwired to zero, so a write to it can never be a dependency.
  always_comb begin
    hit_o = 1'b0;
    if (rd_we_i && (rd_addr_i != '0)) begin
      hit_o = (rs1_used_i && (rs1_addr_i == rd_addr_i)) ||
              (rs2_used_i && (rs2_addr_i == rd_addr_i));
    end
  end

endmodule : hazard_cmp
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/bubble controller for the 5-stage pipeline.
//               Freezes the pipe on a pending data-memory access, inserts a
//               bubble on load-use and decode-branch operand hazards, flushes
//               IF/ID on a decode-resolved redirect, and keeps saturating
//               stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      id_is_branch_i,
  input  logic                      id_redirect_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_reg_write_en_i,
  input  logic                      ex_mem_read_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic                      mem_mem_read_i,
  input  logic                      dmem_req_i,
  input  logic                      dmem_ready_i,
  output logic                      pc_stall_o,
  output logic                      if_id_stall_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_stall_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_stall_o,
  output logic                      mem_wb_flush_o,
  output logic                      mem_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_cycles_o,
  output logic [CNT_WIDTH-1:0]      flush_count_o
);

  import hazard_ctrl_pkg::*;

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e            state_q, state_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 mem_timeout_q;
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] flush_count_q;

  logic w_ex_load_cmp, w_ex_wr_cmp, w_mem_load_cmp;
  logic w_hazard;
  logic w_tmo_set;
  logic w_flush_inc;

  hazard_cmp #(.ADDR_W(REG_ADDR_WIDTH)) u_cmp_ex_load (
    .rd_addr_i (ex_rd_addr_i),  .rd_we_i    (ex_mem_read_i),
    .rs1_addr_i(id_rs1_addr_i), .rs1_used_i (id_rs1_used_i),
    .rs2_addr_i(id_rs2_addr_i), .rs2_used_i (id_rs2_used_i),
    .hit_o     (w_ex_load_cmp)
  );

  hazard_cmp #(.ADDR_W(REG_ADDR_WIDTH)) u_cmp_br_ex (
    .rd_addr_i (ex_rd_addr_i),  .rd_we_i    (ex_reg_write_en_i),
    .rs1_addr_i(id_rs1_addr_i), .rs1_used_i (id_rs1_used_i),
    .rs2_addr_i(id_rs2_addr_i), .rs2_used_i (id_rs2_used_i),
    .hit_o     (w_ex_wr_cmp)
  );

  hazard_cmp #(.ADDR_W(REG_ADDR_WIDTH)) u_cmp_br_mem (
    .rd_addr_i (mem_rd_addr_i), .rd_we_i    (mem_mem_read_i),
    .rs1_addr_i(id_rs1_addr_i), .rs1_used_i (id_rs1_used_i),
    .rs2_addr_i(id_rs2_addr_i), .rs2_used_i (id_rs2_used_i),
    .hit_o     (w_mem_load_cmp)
  );

  // Only a real decode instruction can create a hazard; branch hits matter
  // because the branch compare reads its operands in decode.
  assign w_hazard = id_valid_i &&
                    (w_ex_load_cmp ||
                     (id_is_branch_i && w_ex_wr_cmp) ||
                     (id_is_branch_i && w_mem_load_cmp));

  // Next state and pipeline controls: freeze beats hazard beats redirect.
  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    w_tmo_set      = 1'b0;
    w_flush_inc    = 1'b0;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
          mem_wb_flush_o = 1'b1;
          state_d        = HZ_MEM_WAIT;
          tmo_cnt_d      = '0;
        end else if (w_hazard) begin
          // Redirect is dropped: it was resolved from stale operands.
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (id_redirect_i) begin
          if_id_flush_o = 1'b1;
          w_flush_inc   = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
        tmo_cnt_d      = tmo_cnt_q + TW'(1);
        if (dmem_ready_i) begin
          state_d = HZ_RUN;
        end else if (tmo_cnt_d == TW'(MEM_TIMEOUT)) begin
          w_tmo_set = 1'b1;
          state_d   = HZ_RUN;
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase
  end

  // FSM, timeout timer, sticky error flag and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HZ_RUN;
      tmo_cnt_q      <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      if (w_tmo_set) begin
        mem_timeout_q <= 1'b1;
      end
      if (pc_stall_o && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      end
      if (w_flush_inc && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign mem_timeout_o  = mem_timeout_q;
  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int AW     = 5;
  localparam int CW     = 32;
  localparam int MEM_TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid, id_rs1_used, id_rs2_used, id_is_branch, id_redirect;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
  logic          ex_reg_write_en, ex_mem_read, mem_mem_read, dmem_req, dmem_ready;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit     m_wait;
  int     m_waited;
  bit     m_timeout;
  longint m_stalls;
  longint m_flushes;

  hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_is_branch_i(id_is_branch), .id_redirect_i(id_redirect),
    .ex_rd_addr_i(ex_rd_addr), .ex_reg_write_en_i(ex_reg_write_en),
    .ex_mem_read_i(ex_mem_read), .mem_rd_addr_i(mem_rd_addr),
    .mem_mem_read_i(mem_mem_read), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
    .ex_mem_stall_o(ex_mem_stall), .mem_wb_flush_o(mem_wb_flush),
    .mem_timeout_o(mem_timeout), .stall_cycles_o(stall_cycles),
    .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  // Order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //        ex_mem_stall, mem_wb_flush
  wire [6:0] act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_flush, ex_mem_stall, mem_wb_flush};

  function automatic bit reads(logic [AW-1:0] a);
    return (a != 0) && id_valid &&
           ((id_rs1_used && id_rs1_addr == a) || (id_rs2_used && id_rs2_addr == a));
  endfunction

  function automatic bit exp_freeze();
    return m_wait || (dmem_req && !dmem_ready);
  endfunction

  function automatic bit exp_hazard();
    if (exp_freeze()) return 1'b0;
    return (ex_mem_read && reads(ex_rd_addr)) ||
           (id_is_branch && ex_reg_write_en && reads(ex_rd_addr)) ||
           (id_is_branch && mem_mem_read && reads(mem_rd_addr));
  endfunction

  function automatic bit exp_redirect();
    return !exp_freeze() && !exp_hazard() && id_redirect;
  endfunction

  function automatic logic [6:0] exp_outs();
    if (exp_freeze()) return 7'b1101011;
    if (exp_hazard()) return 7'b1100100;
    if (exp_redirect()) return 7'b0010000;
    return 7'b0000000;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit fr, hz, rd;
    fr = exp_freeze();
    hz = exp_hazard();
    rd = exp_redirect();
    if (rst) begin
      m_wait = 0; m_waited = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if ((fr || hz) && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (rd && m_flushes < 64'hFFFF_FFFF) m_flushes++;
    if (m_wait) begin
      m_waited++;
      if (dmem_ready) m_wait = 0;
      else if (m_waited == MEM_TO) begin
        m_timeout = 1; m_wait = 0;
      end
    end else if (fr) begin
      m_wait = 1; m_waited = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_is_branch = 0; id_redirect = 0; ex_rd_addr = 0;
    ex_reg_write_en = 0; ex_mem_read = 0; mem_rd_addr = 0; mem_mem_read = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (act !== 7'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b expected 0000000/0", act, mem_timeout);
    end
    checks++;
    if (stall_cycles !== 0 || flush_count !== 0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1;
    ex_mem_read = 1; ex_reg_write_en = 1; ex_rd_addr = 5;
    @(negedge clk);
    checks++;
    if (act !== 7'b1100100) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected 1100100", act);
    end
    tick();
    checks++;
    if (stall_cycles !== 1) begin
      errors++;
      $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
    end
    ex_mem_read = 0; ex_reg_write_en = 0; ex_rd_addr = 0;
    mem_mem_read = 1; mem_rd_addr = 5;
    @(negedge clk);
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL load_use_release: got %b expected 0000000", act);
    end
    tick();
  endtask

  task automatic test_branch_after_load();
    longint f0;
    f0 = m_flushes;
    set_idle();
    id_valid = 1; id_is_branch = 1; id_redirect = 1; id_rs2_addr = 7; id_rs2_used = 1;
    ex_mem_read = 1; ex_reg_write_en = 1; ex_rd_addr = 7;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        ex_mem_read = 0; ex_reg_write_en = 0; ex_rd_addr = 0;
        mem_mem_read = 1; mem_rd_addr = 7;
      end
      @(negedge clk);
      checks++;
      if (act !== 7'b1100100) begin
        errors++;
        $display("FAIL br_load_stall%0d: got %b expected 1100100", c, act);
      end
      tick();
    end
    mem_mem_read = 0; mem_rd_addr = 0;
    @(negedge clk);
    checks++;
    if (act !== 7'b0010000) begin
      errors++;
      $display("FAIL br_load_redirect: got %b expected 0010000", act);
    end
    tick();
    checks++;
    if (flush_count !== CW'(f0 + 1)) begin
      errors++;
      $display("FAIL br_load_flush_count: got %0d expected %0d", flush_count, f0 + 1);
    end
  endtask

  task automatic test_x0();
    set_idle();
    id_valid = 1; id_rs1_addr = 0; id_rs1_used = 1;
    ex_mem_read = 1; ex_reg_write_en = 1; ex_rd_addr = 0;
    @(negedge clk);
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL x0_exclusion: got %b expected 0000000", act);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    longint s0;
    set_idle();
    s0 = m_stalls;
    dmem_req = 1;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      @(negedge clk);
      checks++;
      if (act !== 7'b1101011) begin
        errors++;
        $display("FAIL mem_wait_freeze%0d: got %b expected 1101011", c, act);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== CW'(s0 + 4)) begin
      errors++;
      $display("FAIL mem_wait_count: got %0d expected %0d", stall_cycles, s0 + 4);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL mem_wait_release: got %b expected 0000000", act);
    end
    tick();
  endtask

  task automatic test_redirect_freeze();
    longint f0;
    set_idle();
    f0 = m_flushes;
    id_redirect = 1; dmem_req = 1;
    for (int c = 0; c < 2; c++) begin
      dmem_ready = (c == 1);
      @(negedge clk);
      checks++;
      if (act !== 7'b1101011) begin
        errors++;
        $display("FAIL redir_frozen%0d: got %b expected 1101011", c, act);
      end
      tick();
    end
    checks++;
    if (flush_count !== CW'(f0)) begin
      errors++;
      $display("FAIL redir_frozen_count: got %0d expected %0d", flush_count, f0);
    end
    dmem_req = 0; dmem_ready = 0;
    @(negedge clk);
    checks++;
    if (act !== 7'b0010000) begin
      errors++;
      $display("FAIL redir_release: got %b expected 0010000", act);
    end
    tick();
    checks++;
    if (flush_count !== CW'(f0 + 1)) begin
      errors++;
      $display("FAIL redir_release_count: got %0d expected %0d", flush_count, f0 + 1);
    end
  endtask

  task automatic test_timeout_reset();
    set_idle();
    dmem_req = 1;
    // One RUN cycle entering the wait, then MEM_TO wait cycles.
    for (int c = 0; c <= MEM_TO; c++) begin
      @(negedge clk);
      checks++;
      if (mem_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early%0d: got %b expected 0", c, mem_timeout);
      end
      tick();
    end
    set_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_timeout !== 1'b1 || act !== 7'b0) begin
        errors++;
        $display("FAIL timeout_sticky%0d: got %b/%b expected 1/0000000", c, mem_timeout, act);
      end
      tick();
    end
    // Reset while parked in the wait state.
    dmem_req = 1;
    tick();
    tick();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (act !== 7'b0 || mem_timeout !== 1'b0 || stall_cycles !== 0 || flush_count !== 0) begin
      errors++;
      $display("FAIL timeout_reset: got %b/%b/%0d/%0d expected all zero",
               act, mem_timeout, stall_cycles, flush_count);
    end
    id_redirect = 1;
    #1;
    checks++;
    if (act !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_in_run: got %b expected 0010000", act);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 59) == 0);
      id_valid        = ($urandom_range(0, 7) != 0);
      id_rs1_addr     = AW'($urandom_range(0, 3));
      id_rs2_addr     = AW'($urandom_range(0, 3));
      id_rs1_used     = $urandom_range(0, 1) == 1;
      id_rs2_used     = $urandom_range(0, 1) == 1;
      id_is_branch    = $urandom_range(0, 1) == 1;
      id_redirect     = $urandom_range(0, 1) == 1;
      ex_rd_addr      = AW'($urandom_range(0, 3));
      ex_reg_write_en = $urandom_range(0, 1) == 1;
      ex_mem_read     = ($urandom_range(0, 3) == 0);
      mem_rd_addr     = AW'($urandom_range(0, 3));
      mem_mem_read    = ($urandom_range(0, 3) == 0);
      dmem_req        = ($urandom_range(0, 4) == 0);
      dmem_ready      = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checks++;
      if (act !== exp_outs()) begin
        errors++;
        $display("FAIL rand_outs[%0d]: got %b expected %b", n, act, exp_outs());
      end
      tick();
      checks++;
      if (stall_cycles !== CW'(m_stalls) || flush_count !== CW'(m_flushes) ||
          mem_timeout !== m_timeout) begin
        errors++;
        $display("FAIL rand_state[%0d]: got %0d/%0d/%b expected %0d/%0d/%b", n,
                 stall_cycles, flush_count, mem_timeout, m_stalls, m_flushes, m_timeout);
      end
    end
    rst = 0;
    set_idle();
    tick();
  endtask

  initial begin
    m_wait = 0; m_waited = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_x0();
    test_mem_wait();
    test_redirect_freeze();
    test_timeout_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the IF/ID/EXE/MEM/WB registers and drives their stall, flush and bubble controls from the decoded operand addresses, the in-flight destination registers, the decode-stage branch resolution (br_true, jal/jalr redirect) and the data-memory handshake. It also keeps saturating performance counters for stall cycles and flushes.

Parameters:
REG_ADDR_WIDTH, 5, register address width, from constants.vh.
CNT_WIDTH, 32, width of each performance counter.
MEM_TIMEOUT, 255, maximum cycles spent in MEM_WAIT before mem_timeout is raised.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
id_valid  in  1  decode holds a real instruction (not a bubble).
id_rs1_addr  in  REG_ADDR_WIDTH  rs1 of the instruction in decode.
id_rs2_addr  in  REG_ADDR_WIDTH  rs2 of the instruction in decode.
id_rs1_used  in  1  decode instruction reads rs1.
id_rs2_used  in  1  decode instruction reads rs2.
id_is_branch  in  1  decode instruction is a branch or jalr (compare/target computed in decode).
id_redirect  in  1  decode resolved a taken branch, jal or jalr (br_true or jump).
ex_rd_addr  in  REG_ADDR_WIDTH  destination register of the instruction in EXE.
ex_reg_write_en  in  1  EXE instruction writes rd.
ex_mem_read  in  1  EXE instruction is a load.
mem_rd_addr  in  REG_ADDR_WIDTH  destination register of the instruction in MEM.
mem_mem_read  in  1  MEM instruction is a load.
dmem_req  in  1  MEM stage has an outstanding data-memory access.
dmem_ready  in  1  data memory completes the access this cycle.
pc_stall  out  1  hold the PC.
if_id_stall  out  1  hold the IF/ID register.
if_id_flush  out  1  load a bubble into IF/ID.
id_ex_stall  out  1  hold the ID/EXE register.
id_ex_flush  out  1  load a bubble into ID/EXE.
ex_mem_stall  out  1  hold the EXE/MEM register.
mem_wb_flush  out  1  load a bubble into MEM/WB.
mem_timeout  out  1  sticky error flag for a stuck memory access.
stall_cycles  out  CNT_WIDTH  count of cycles with pc_stall asserted.
flush_count  out  CNT_WIDTH  count of redirect flushes.

Behaviour:
- FSM states: RUN and MEM_WAIT. Reset goes to RUN. All outputs are 0 after reset, the counters are 0, and mem_timeout is 0.
- Hazard terms (combinational; a match requires a nonzero address and an id_valid instruction):
  - hit_ex_load: ex_mem_read and ex_rd_addr matches a used rs.
  - hit_br_ex: id_is_branch, ex_reg_write_en, and ex_rd_addr matches a used rs.
  - hit_br_mem: id_is_branch, mem_mem_read, and mem_rd_addr matches a used rs.
  - hazard = hit_ex_load or hit_br_ex or hit_br_mem.
- Priority: MEM_WAIT freeze > data hazard > redirect.
- RUN with dmem_req and not dmem_ready:
  - Same cycle: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush.
  - Next state is MEM_WAIT and the timeout counter is cleared.
- RUN with hazard (and no freeze):
  - Assert pc_stall, if_id_stall and id_ex_flush.
  - id_redirect is ignored, because the operands are stale.
  - This is one cycle per evaluation; a branch after a load stalls 2 cycles (EXE hit, then MEM hit).
- RUN with id_redirect, no hazard and no freeze: assert if_id_flush only; flush_count increments.
- MEM_WAIT: all freeze outputs stay asserted and the timeout counter increments.
  - dmem_ready: freeze outputs still asserted this cycle; next state is RUN.
  - Timeout counter reaching MEM_TIMEOUT: set mem_timeout (sticky until rst) and return to RUN.
- Hazard and redirect evaluation are suppressed while frozen.
- Outputs are combinational from state and inputs; the counters and the FSM are registered.
- Counters saturate at all-ones. stall_cycles increments on every cycle with pc_stall = 1.
- rst asserted mid-MEM_WAIT: the next cycle is RUN with all outputs 0; pending hazards are re-evaluated from the inputs only.

Decomposition:
- Shared package/constants: the FSM state enum (HZ_RUN, HZ_MEM_WAIT), REG_ADDR_WIDTH and XLEN, reused from constants.vh.
- One natural sub-module, hazard_cmp: a pure combinational rs/rd match that takes addr, used and write-enable and applies the x0 exclusion. It is instanced for each hit term.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 used -> 1 cycle with pc_stall=if_id_stall=id_ex_flush=1 and stall_cycles=1; the next cycle (load moved to MEM, no branch) has no stall.
- Branch-after-load: id_is_branch, rs2=7, load rd=7 in EXE then MEM -> 2 consecutive stall cycles, id_redirect ignored both cycles, then if_id_flush=1 in cycle 3 and flush_count=1.
- x0 exclusion: ex_mem_read=1, ex_rd=0, id_rs1=0 used -> no stall.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles then high -> freeze outputs high for 4 cycles, then RUN; stall_cycles=4.
- Timeout and reset: MEM_TIMEOUT=4 and dmem_ready held low -> mem_timeout=1 after 4 MEM_WAIT cycles and stays high; rst pulse -> all outputs and counters 0, FSM in RUN.
- Redirect with simultaneous freeze: id_redirect=1 while dmem_req pending -> if_id_flush=0 and flush_count unchanged; after release with id_redirect=1 -> if_id_flush=1.
